halfband_fir_tdm: RTL and testbench



---
 rtl/halfband_fir_tdm_if.sv | 29 ++
 rtl/halfband_fir_tdm.sv | 165 ++++++++++++++++
 tb/tb_halfband_fir_tdm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/halfband_fir_tdm_if.sv
// rtl/halfband_fir_tdm_if.sv - sample, coefficient and result signals of the TDM halfband FIR
interface halfband_fir_tdm_if #(
    parameter int WIDTH      = 18,
    parameter int COEF_WIDTH = 18,
    parameter int NUM_UNIQUE = 4
);
    localparam int AW = $clog2(NUM_UNIQUE);

    logic                         sam_clk_en;
    logic signed [WIDTH-1:0]      x_in;
    logic                         coef_we;
    logic        [AW-1:0]         coef_addr;
    logic signed [COEF_WIDTH-1:0] coef_wdata;
    logic signed [WIDTH-1:0]      y;
    logic                         y_valid;
    logic                         busy;
    logic                         overrun;
    logic                         sat;

    modport master (
        output sam_clk_en, x_in, coef_we, coef_addr, coef_wdata,
        input  y, y_valid, busy, overrun, sat
    );

    modport slave (
        input  sam_clk_en, x_in, coef_we, coef_addr, coef_wdata,
        output y, y_valid, busy, overrun, sat
    );
endinterface

// File: rtl/halfband_fir_tdm.sv
// rtl/halfband_fir_tdm.sv - time-multiplexed symmetric halfband FIR, one shared multiplier (optional HBF_ROUND_EN: round half up)
module halfband_fir_tdm #(
    parameter int WIDTH        = 18,
    parameter int COEF_WIDTH   = 18,
    parameter int NUM_UNIQUE   = 4,
    parameter int CENTER_SHIFT = 1
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    halfband_fir_tdm_if.slave bus
);
    localparam int LENGTH = 4 * NUM_UNIQUE - 1;
    localparam int CENTRE = (LENGTH - 1) / 2;
    localparam int AW     = $clog2(NUM_UNIQUE);
    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = WIDTH + COEF_WIDTH + AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREADD = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic [AW-1:0] CNT_LAST = AW'(NUM_UNIQUE - 1);
    localparam logic [AW:0]   NU_L     = (AW + 1)'(NUM_UNIQUE);

    // Output clip limits expressed at accumulator width so the comparison is exact
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

`ifdef HBF_ROUND_EN
    // Half an output LSB: output LSB sits at bit COEF_WIDTH-1 of the sum
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_WIDTH - 2);
`endif

    logic [1:0]                   state;
    logic signed [WIDTH-1:0]      dline [LENGTH];
    logic signed [WIDTH-1:0]      pre   [NUM_UNIQUE];
    logic signed [WIDTH-1:0]      centre;
    logic signed [COEF_WIDTH-1:0] coef  [NUM_UNIQUE];
    logic        [AW-1:0]         cnt;
    logic signed [ACC_W-1:0]      acc;

    logic signed [WIDTH-1:0]      y_r;
    logic                         y_valid_r;
    logic                         overrun_r;
    logic                         sat_r;

    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      centre_term;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      rounded;
    logic signed [ACC_W-1:0]      shifted;
    logic signed [WIDTH-1:0]      y_next;
    logic                         sat_next;
    logic                         coef_addr_ok;

    assign bus.y       = y_r;
    assign bus.y_valid = y_valid_r;
    assign bus.overrun = overrun_r;
    assign bus.sat     = sat_r;
    assign bus.busy    = (state != S_IDLE);

    assign coef_addr_ok = ({1'b0, bus.coef_addr} < NU_L);

    // The single shared multiplier: one coefficient times one pre-added pair per MAC cycle
    assign prod     = coef[cnt] * pre[cnt];
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Centre tap is a power of two, so it enters the sum as a shifted sample
    assign centre_term = {{(ACC_W - WIDTH){centre[WIDTH-1]}}, centre} <<< (COEF_WIDTH - CENTER_SHIFT);
    assign sum         = acc + centre_term;

`ifdef HBF_ROUND_EN
    assign rounded = sum + RND;
`else
    assign rounded = sum;
`endif

    assign shifted = rounded >>> (COEF_WIDTH - 1);

    // Clip the rescaled sum to the output range and flag when clipping happened
    always_comb begin
        y_next   = shifted[WIDTH-1:0];
        sat_next = 1'b0;
        if (shifted > Y_MAX) begin
            y_next   = Y_MAX[WIDTH-1:0];
            sat_next = 1'b1;
        end else if (shifted < Y_MIN) begin
            y_next   = Y_MIN[WIDTH-1:0];
            sat_next = 1'b1;
        end
    end

    // Sequencer: accept a sample, pre-add symmetric pairs, multiply-accumulate, then emit
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            centre    <= '0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            overrun_r <= 1'b0;
            sat_r     <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                dline[i] <= '0;
            end
            for (int k = 0; k < NUM_UNIQUE; k++) begin
                pre[k] <= '0;
            end
        end else begin
            y_valid_r <= 1'b0;
            sat_r     <= 1'b0;
            // A strobe while a sample is in flight is dropped and reported
            overrun_r <= bus.sam_clk_en && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (bus.sam_clk_en) begin
                        dline[0] <= bus.x_in >>> 1;
                        for (int i = 1; i < LENGTH; i++) begin
                            dline[i] <= dline[i-1];
                        end
                        state <= S_PREADD;
                    end
                end
                S_PREADD: begin
                    // Halved samples keep the pair sum inside WIDTH bits
                    for (int k = 0; k < NUM_UNIQUE; k++) begin
                        pre[k] <= dline[2*k] + dline[LENGTH-1-2*k];
                    end
                    centre <= dline[CENTRE];
                    cnt    <= '0;
                    state  <= S_MAC;
                end
                S_MAC: begin
                    if (cnt == '0) begin
                        acc <= prod_ext;
                    end else begin
                        acc <= acc + prod_ext;
                    end
                    if (cnt == CNT_LAST) begin
                        state <= S_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    y_r       <= y_next;
                    y_valid_r <= 1'b1;
                    sat_r     <= sat_next;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Coefficient bank survives reset; writes land only between samples
    always_ff @(posedge sys_clk) begin
        if (reset_n && bus.coef_we && (state == S_IDLE) && coef_addr_ok) begin
            coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end
endmodule

// File: tb/tb_halfband_fir_tdm.sv
// tb/tb_halfband_fir_tdm.sv - directed table-driven bench for halfband_fir_tdm
module tb_halfband_fir_tdm;
    localparam int WIDTH = 18;
    localparam int CW    = 18;
    localparam int NU    = 4;

    typedef struct {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
        logic                    sat;
    } vec_t;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    int errors  = 0;
    int checks  = 0;
    int ovr_cnt = 0;
    int vld_cnt = 0;

`ifdef HBF_ROUND_EN
    int exp_imp [17] = '{-87, 0, 819, 0, -3981, 0, 19634, 32768, 19634, 0, -3981, 0, 819, 0, -87, 0, 0};
    int exp_sat_first = 65535;
`else
    int exp_imp [17] = '{-87, 0, 818, 0, -3982, 0, 19633, 32768, 19633, 0, -3982, 0, 818, 0, -87, 0, 0};
    int exp_sat_first = 65534;
`endif

    vec_t imp [17];

    always #5 sys_clk = ~sys_clk;

    halfband_fir_tdm_if #(.WIDTH(WIDTH), .COEF_WIDTH(CW), .NUM_UNIQUE(NU)) bus ();

    halfband_fir_tdm #(
        .WIDTH(WIDTH), .COEF_WIDTH(CW), .NUM_UNIQUE(NU), .CENTER_SHIFT(1)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(negedge sys_clk) begin
        if (bus.overrun) ovr_cnt++;
        if (bus.y_valid) vld_cnt++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge sys_clk);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 2'(addr);
        bus.coef_wdata = 18'(data);
        @(negedge sys_clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        reset_n = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    // mode 0 plain, 1 strobe+coef write during MAC, 2 reset during MAC, 3 coef0 write on the strobe edge
    task automatic strobe(input logic signed [WIDTH-1:0] x, input int mode, input int wdata,
                          output int lat, output logic b_early, output logic b_late,
                          output logic signed [WIDTH-1:0] y_o, output logic s_o);
        lat    = -1;
        b_late = 1'b1;
        y_o    = '0;
        s_o    = 1'b0;
        @(negedge sys_clk);
        bus.sam_clk_en = 1'b1;
        bus.x_in       = x;
        if (mode == 3) begin
            bus.coef_we    = 1'b1;
            bus.coef_addr  = 2'd0;
            bus.coef_wdata = 18'(wdata);
        end
        @(negedge sys_clk);
        bus.sam_clk_en = 1'b0;
        bus.coef_we    = 1'b0;
        bus.x_in       = '0;
        b_early        = bus.busy;
        for (int i = 2; i <= 20; i++) begin
            @(negedge sys_clk);
            if (mode == 1 && i == 3) begin
                bus.sam_clk_en = 1'b1;
                bus.x_in       = 18'sd12345;
                bus.coef_we    = 1'b1;
                bus.coef_addr  = 2'd0;
                bus.coef_wdata = 18'sd5;
            end else if (mode == 2 && i == 3) begin
                reset_n = 1'b0;
            end else begin
                bus.sam_clk_en = 1'b0;
                bus.coef_we    = 1'b0;
                reset_n        = 1'b1;
            end
            if (bus.y_valid && lat < 0) begin
                lat    = i;
                b_late = bus.busy;
                y_o    = bus.y;
                s_o    = bus.sat;
            end
            if (lat >= 0 && i >= lat + 1) break;
        end
    endtask

    task automatic run_impulse(input string tag, input int inject_at);
        int lat;
        logic be, bl, so;
        logic signed [WIDTH-1:0] yo;
        for (int i = 0; i < 17; i++) begin
            strobe(imp[i].x, (i == inject_at) ? 1 : 0, 0, lat, be, bl, yo, so);
            check($sformatf("%s y[%0d]", tag, i), yo, imp[i].y);
            check($sformatf("%s sat[%0d]", tag, i), so, imp[i].sat);
            check($sformatf("%s latency[%0d]", tag, i), lat, 7);
            if (i == 0) begin
                check($sformatf("%s busy_after_strobe", tag), be, 1);
                check($sformatf("%s busy_in_valid", tag), bl, 0);
            end
        end
    endtask

    initial begin
        int lat, ovr0, vld0;
        logic be, bl, so;
        logic signed [WIDTH-1:0] yo;

        for (int i = 0; i < 17; i++) begin
            imp[i].x   = (i == 0) ? 18'sd65536 : 18'sd0;
            imp[i].y   = 18'(exp_imp[i]);
            imp[i].sat = 1'b0;
        end

        bus.sam_clk_en = 1'b0;
        bus.x_in       = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;

        repeat (3) @(negedge sys_clk);
        check("reset y", bus.y, 0);
        check("reset y_valid", bus.y_valid, 0);
        check("reset overrun", bus.overrun, 0);
        check("reset sat", bus.sat, 0);
        check("reset busy", bus.busy, 0);
        reset_n = 1'b1;

        write_coef(0, -348);
        write_coef(1, 3274);
        write_coef(2, -15925);
        write_coef(3, 78535);
        run_impulse("impulse", -1);

        ovr0 = ovr_cnt;
        run_impulse("overrun", 0);
        repeat (2) @(negedge sys_clk);
        check("overrun pulses", ovr_cnt - ovr0, 1);

        strobe(18'sd65536, 0, 0, lat, be, bl, yo, so);
        strobe(18'sd0, 0, 0, lat, be, bl, yo, so);
        strobe(18'sd0, 0, 0, lat, be, bl, yo, so);
        check("pre-reset y", yo, imp[2].y);
        vld0 = vld_cnt;
        strobe(18'sd0, 2, 0, lat, be, bl, yo, so);
        check("reset no y_valid", vld_cnt - vld0, 0);
        check("reset latency none", lat, -1);
        check("reset y cleared", bus.y, 0);
        check("reset busy cleared", bus.busy, 0);
        run_impulse("after_reset", -1);

        pulse_reset();
        strobe(18'sd65536, 3, -696, lat, be, bl, yo, so);
        check("same-edge coef y", yo, -174);
        check("same-edge coef latency", lat, 7);
        write_coef(0, -348);
        pulse_reset();

        for (int k = 0; k < NU; k++) write_coef(k, 131071);
        strobe(18'sd131071, 0, 0, lat, be, bl, yo, so);
        check("sat first y", yo, exp_sat_first);
        check("sat first flag", so, 0);
        for (int n = 1; n < 16; n++) strobe(18'sd131071, 0, 0, lat, be, bl, yo, so);
        check("sat pos y", yo, 131071);
        check("sat pos flag", so, 1);
        for (int k = 0; k < NU; k++) write_coef(k, -131072);
        strobe(18'sd131071, 0, 0, lat, be, bl, yo, so);
        check("sat neg y", yo, -131072);
        check("sat neg flag", so, 1);
        check("sat neg latency", lat, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
